// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// matrix_pkg: shared types and constants for the 5x7 LED matrix scanner.
// Revision: 1.0
// ============================================================================

package matrix_pkg;

  localparam int MATRIX_COLUMNS = 5;
  localparam int MATRIX_ROWS    = 7;

  typedef logic [2:0]                column_index_t;
  typedef logic [MATRIX_ROWS-1:0]    row_pattern_t;
  typedef logic [MATRIX_COLUMNS-1:0] column_onehot_t;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam column_index_t LAST_COLUMN = column_index_t'(MATRIX_COLUMNS - 1);

  function automatic column_onehot_t column_onehot(input column_index_t idx);
    column_onehot_t result;
    result = '0;
    for (int i = 0; i < MATRIX_COLUMNS; i++) begin
      if (idx == column_index_t'(i)) result[i] = 1'b1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_frame_buffer.sv
`default_nettype none
// ============================================================================
// matrix_frame_buffer: two 5x7 banks; writes go to the back bank, reads come
// from the front bank, and swap exchanges their roles.
// Revision: 1.0
// ============================================================================

module matrix_frame_buffer
  import matrix_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  column_index_t wr_column,
  input  row_pattern_t  wr_data,
  input  logic          swap,
  input  column_index_t rd_column,
  output row_pattern_t  rd_data
);

  row_pattern_t bank_q [2][MATRIX_COLUMNS];
  row_pattern_t bank_d [2][MATRIX_COLUMNS];
  logic         front_sel_q;
  logic         front_sel_d;

  // Column indices above the last column match no entry, so they write nothing.
  always_comb begin
    bank_d      = bank_q;
    front_sel_d = front_sel_q ^ swap;
    for (int i = 0; i < MATRIX_COLUMNS; i++) begin
      if (wr_en && (wr_column == column_index_t'(i))) begin
        bank_d[~front_sel_q][i] = wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MATRIX_COLUMNS; i++) begin
      if (rd_column == column_index_t'(i)) rd_data = bank_q[front_sel_q][i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q      <= '{default: '0};
      front_sel_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      front_sel_q <= front_sel_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/matrix_scan_controller.sv
`default_nettype none
// ============================================================================
// matrix_scan_controller: blank/drive column scan of the 5x7 LED matrix with
// a double-buffered frame store swapped at frame boundaries.
// Revision: 1.0
// ============================================================================

module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [2:0] load_column,
  input  logic [6:0] load_data,
  input  logic       commit,
  output logic       swap_pending,
  output logic [4:0] column_enable,
  output logic [6:0] row_data,
  output logic       column_advance,
  output logic       frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  column_index_t    column_q, column_d;
  logic             swap_pending_q, swap_pending_d;
  column_onehot_t   column_enable_q, column_enable_d;
  row_pattern_t     row_data_q, row_data_d;
  logic             column_advance_q, column_advance_d;
  logic             frame_done_q, frame_done_d;

  logic             drive_end;
  logic             frame_end;
  logic             swap;
  logic             load_fire;
  row_pattern_t     front_row;

  matrix_frame_buffer u_frame_buffer (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (load_fire),
    .wr_column (column_index_t'(load_column)),
    .wr_data   (row_pattern_t'(load_data)),
    .swap      (swap),
    .rd_column (column_d),
    .rd_data   (front_row)
  );

  always_comb begin
    drive_end = (state_q == DRIVE) && (count_q == DWELL_LAST);
    frame_end = drive_end && (column_q == LAST_COLUMN);
    swap      = frame_end && swap_pending_q;
    load_fire = load_valid && !swap_pending_q;

    state_d  = state_q;
    count_d  = count_q + CNT_W'(1);
    column_d = column_q;
    case (state_q)
      BLANK: begin
        if (count_q == BLANK_LAST) begin
          state_d = DRIVE;
          count_d = '0;
        end
      end
      DRIVE: begin
        if (drive_end) begin
          state_d  = BLANK;
          count_d  = '0;
          column_d = (column_q == LAST_COLUMN) ? '0 : column_q + column_index_t'(1);
        end
      end
      default: begin
        state_d = BLANK;
        count_d = '0;
      end
    endcase

    // Outputs are computed from next state so they register alongside it.
    column_enable_d = '0;
    row_data_d      = '0;
    if (state_d == DRIVE) begin
      column_enable_d = column_onehot(column_d);
      row_data_d      = front_row;
    end
    column_advance_d = (state_d == DRIVE) && (count_d == DWELL_LAST);
    frame_done_d     = column_advance_d && (column_d == LAST_COLUMN);

    // A commit landing on the boundary edge without a pending swap waits a frame.
    swap_pending_d = swap ? 1'b0 : (swap_pending_q | commit);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= BLANK;
      count_q          <= '0;
      column_q         <= '0;
      swap_pending_q   <= 1'b0;
      column_enable_q  <= '0;
      row_data_q       <= '0;
      column_advance_q <= 1'b0;
      frame_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      column_q         <= column_d;
      swap_pending_q   <= swap_pending_d;
      column_enable_q  <= column_enable_d;
      row_data_q       <= row_data_d;
      column_advance_q <= column_advance_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign load_ready     = ~swap_pending_q;
  assign swap_pending   = swap_pending_q;
  assign column_enable  = column_enable_q;
  assign row_data       = row_data_q;
  assign column_advance = column_advance_q;
  assign frame_done     = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_matrix_scan_controller: scoreboard bench; each column_advance pops one
// expected column (cycle, enable, rows, frame_done) pushed by the stimulus.
// Revision: 1.0
// ============================================================================

module tb_matrix_scan_controller;

  localparam int DW  = 4;
  localparam int BL  = 2;
  localparam int COL = DW + BL;

  typedef struct {
    string      name;
    int         cyc;
    logic [4:0] en;
    logic [6:0] row;
    logic       fd;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [2:0] load_column = 3'd0;
  logic [6:0] load_data = 7'd0;
  logic       commit = 1'b0;
  logic       swap_pending;
  logic [4:0] column_enable;
  logic [6:0] row_data;
  logic       column_advance;
  logic       frame_done;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];

  matrix_scan_controller #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_column    (load_column),
    .load_data      (load_data),
    .commit         (commit),
    .swap_pending   (swap_pending),
    .column_enable  (column_enable),
    .row_data       (row_data),
    .column_advance (column_advance),
    .frame_done     (frame_done)
  );

  always #5 clock = ~clock;

  // Cycle 0 is the first cycle after the last edge that sampled reset high.
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    int guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    check($sformatf("reach_cycle_%0d", n), cyc, n);
  endtask

  task automatic push_frame(input int f, input logic [34:0] rows, input int ncols);
    exp_t e;
    for (int c = 0; c < ncols; c++) begin
      e.name = $sformatf("frame%0d_col%0d", f, c);
      e.cyc  = BL + DW - 1 + COL * (5 * f + c);
      e.en   = 5'b00001 << c;
      e.row  = rows[7*c +: 7];
      e.fd   = (c == 4);
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_enable"}, int'(column_enable), 0);
    check({tag, "_row"}, int'(row_data), 0);
    check({tag, "_advance"}, int'(column_advance), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_swap_pending"}, int'(swap_pending), 0);
    check({tag, "_load_ready"}, int'(load_ready), 1);
  endtask

  task automatic check_first_column(input string tag);
    for (int n = 0; n < BL + DW; n++) begin
      goto(n);
      check($sformatf("%s_enable_c%0d", tag, n), int'(column_enable), (n < BL) ? 0 : 1);
      check($sformatf("%s_advance_c%0d", tag, n), int'(column_advance), (n == BL + DW - 1) ? 1 : 0);
    end
  endtask

  // Monitor: every column_advance must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (column_advance) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL advance_unexpected: actual advance at cyc %0d required none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cyc != e.cyc || column_enable != e.en || row_data != e.row || frame_done != e.fd) begin
            n_fail++;
            $display("FAIL %s: actual cyc=%0d en=%b row=%h fd=%b required cyc=%0d en=%b row=%h fd=%b",
                     e.name, cyc, column_enable, row_data, frame_done, e.cyc, e.en, e.row, e.fd);
          end
        end
      end
      if (frame_done && !column_advance) begin
        n_cmp++;
        n_fail++;
        $display("FAIL frame_done_alone: actual frame_done=1 advance=0 at cyc %0d required advance=1", cyc);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;

    push_frame(0, 35'd0, 5);
    push_frame(1, 35'd0, 5);
    check_first_column("start");

    // Load col2 and col4, then commit.
    goto(34);
    load_valid = 1'b1; load_column = 3'd2; load_data = 7'h55;
    @(negedge clock);
    load_column = 3'd4; load_data = 7'h2A;
    @(negedge clock);
    load_valid = 1'b0; commit = 1'b1;
    @(negedge clock);
    commit = 1'b0;
    check("pending_after_commit", int'(swap_pending), 1);
    check("ready_after_commit", int'(load_ready), 0);

    // Write offered while pending must be refused.
    goto(45);
    load_valid = 1'b1; load_column = 3'd0; load_data = 7'h7F;
    check("ready_blocked", int'(load_ready), 0);
    @(negedge clock);
    load_valid = 1'b0;

    goto(59);
    check("pending_at_boundary", int'(swap_pending), 1);
    push_frame(2, {7'h2A, 7'h00, 7'h55, 7'h00, 7'h00}, 5);
    goto(60);
    check("pending_after_swap", int'(swap_pending), 0);
    check("ready_after_swap", int'(load_ready), 1);

    // New back frame, including an out-of-range write after col1.
    goto(64);
    load_valid = 1'b1; load_column = 3'd1; load_data = 7'h11;
    @(negedge clock);
    load_column = 3'd6; load_data = 7'h7F;
    @(negedge clock);
    load_column = 3'd3; load_data = 7'h33;
    @(negedge clock);
    load_valid = 1'b0;
    push_frame(3, {7'h2A, 7'h00, 7'h55, 7'h00, 7'h00}, 5);
    push_frame(4, {7'h00, 7'h33, 7'h00, 7'h11, 7'h00}, 5);
    push_frame(5, {7'h00, 7'h33, 7'h00, 7'h11, 7'h00}, 3);

    // Commit in the frame_done cycle: swap deferred one full frame.
    goto(89);
    check("frame_done_at_89", int'(frame_done), 1);
    commit = 1'b1;
    @(negedge clock);
    commit = 1'b0;
    check("pending_after_boundary_commit", int'(swap_pending), 1);
    goto(119);
    check("pending_before_deferred_swap", int'(swap_pending), 1);
    goto(120);
    check("pending_after_deferred_swap", int'(swap_pending), 0);

    // Pending commit, then reset during column 3 drive.
    goto(155);
    commit = 1'b1;
    @(negedge clock);
    commit = 1'b0;
    goto(160);
    check("pending_before_reset", int'(swap_pending), 1);
    check("ready_before_reset", int'(load_ready), 0);
    goto(171);
    check("col3_driven_before_reset", int'(column_enable), 5'b01000);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("midreset");
    reset = 1'b0;

    push_frame(0, 35'd0, 2);
    check_first_column("restart");
    goto(14);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_scan_controller.md
# matrix_scan_controller

Sequences multiplexed refresh of the 5-column × 7-row LED status matrix. Generates the column-advance strobe that steps `matrix_column_selector`, and drives a one-hot column enable with blanking between columns to suppress ghosting. Presents the row pattern of the active column from a double-buffered frame store. Sits between the irrigation status logic, which writes frames, and the matrix drive pins.

## Interface
- `DWELL_CYCLES`, default 1000: clock cycles each column is driven; minimum 1.
- `BLANK_CYCLES`, default 8: clock cycles all columns are off before each column is driven; minimum 1.
- `clock` input 1: single clock domain.
- `reset` input 1: synchronous, active-high; sampled on the `clock` rising edge.
- `load_valid` input 1: a back-buffer write is offered.
- `load_ready` output 1: back buffer can accept a write.
- `load_column` input 3: column index, 0..4, for the write.
- `load_data` input 7: row pattern; bit 0 is the top row.
- `commit` input 1: single-cycle request to display the back buffer from the next frame boundary.
- `swap_pending` output 1: a commit is waiting for the frame boundary.
- `column_enable` output 5: one-hot active column; index 0 = `5'b00001`, index 4 = `5'b10000`; all zero while blanking.
- `row_data` output 7: front-buffer pattern of the active column; zero while blanking.
- `column_advance` output 1: one-cycle strobe that steps the external column selector.
- `frame_done` output 1: one-cycle strobe at the end of column 4's drive window.

## Operation
- **Reset values:**
  - Outputs: `column_enable`=0, `row_data`=0, `column_advance`=0, `frame_done`=0, `swap_pending`=0, `load_ready`=1.
  - Internal state: column index 0; state BLANK; dwell counter 0; both buffers cleared to 0; front select 0.
- **State machine:**
  - BLANK counts `BLANK_CYCLES` cycles, then goes to DRIVE.
  - DRIVE counts `DWELL_CYCLES` cycles, then goes to BLANK.
  - On the DRIVE→BLANK transition the column index increments. After 4 it wraps to 0.
- **Strobes:**
  - `column_advance` is high during the last DRIVE cycle of every column. The external selector therefore steps on the same edge that enters BLANK.
  - `frame_done` is high during the last DRIVE cycle of column 4.
- **Load handshake:**
  - A write happens on any edge where `load_valid && load_ready`: back[`load_column`] ← `load_data`.
  - `load_column` > 4 completes the handshake but writes nothing.
  - `load_ready` = !`swap_pending`. No writes are accepted between commit and swap.
- **Commit:**
  - `commit` sets `swap_pending` on the next edge. Commits while already pending are ignored.
  - The swap happens on the edge that ends column 4's DRIVE, while `swap_pending` is registered high. On that edge the front select toggles and `swap_pending` clears.
- **Simultaneous events:**
  - `load_valid`, `load_ready` and `commit` in the same cycle: the write lands in the back buffer, then becomes pending. It is included in the swapped frame.
  - `commit` during the frame-boundary cycle with `swap_pending` low: it does not swap at that edge. It sets `swap_pending` and swaps at the following frame boundary.
- **Reset mid-operation:** aborts any drive or blank phase and clears any pending swap. All outputs return to their reset values on the next edge.

## Timing
- All outputs are registered. `row_data` and `column_enable` change on the same edge.
- Column period = `BLANK_CYCLES` + `DWELL_CYCLES`. Frame period = 5 × column period.
- Counter width = clog2(max(`DWELL_CYCLES`, `BLANK_CYCLES`)).
- After reset deasserts:
  - Cycles 0..`BLANK_CYCLES`-1 are blank.
  - Column 0 is driven from cycle `BLANK_CYCLES` for `DWELL_CYCLES` cycles.
- Latency rules:
  - A write becomes visible only after a commit and the next swap.
  - Display latency from commit to new data: at most one frame plus one cycle.

## Structure
- Package `matrix_pkg` holds:
  - constants `MATRIX_COLUMNS`=5 and `MATRIX_ROWS`=7;
  - typedefs `column_index_t` (3 bits), `row_pattern_t` (7 bits) and `column_onehot_t` (5 bits);
  - state enum `scan_state_t` with values BLANK and DRIVE.
- Sub-module `matrix_frame_buffer` holds the two 5×7 banks, the front select, and the write and read ports.
- The controller holds the FSM, counters, strobes and the commit/swap logic.

## Test plan
- **Reset and first column:** `DWELL`=4, `BLANK`=2, all buffers zero.
  - Expect `column_enable`=0 for cycles 0–1.
  - Expect `5'b00001` for cycles 2–5, with `column_advance` high only in cycle 5.
- **Scan wrap:** run 2 frames with `DWELL`=4, `BLANK`=2.
  - Expect the enables sequence 00001→00010→00100→01000→10000→00001.
  - Expect `frame_done` high in cycles 29 and 59 only.
- **Load, commit, swap:**
  - Write col2=`7'h55` and col4=`7'h2A`, then commit.
  - Expect `swap_pending`=1 and `load_ready`=0 until the frame boundary.
  - In the next frame expect `row_data`=`7'h55` while enable=`5'b00100`, and `7'h2A` while enable=`5'b10000`.
- **Commit on boundary:** assert `commit` in the `frame_done` cycle with `swap_pending`=0.
  - Expect the old data for one more full frame, then the new data.
- **Out-of-range and blocked writes:**
  - `load_column`=6 with data `7'h7F`: expect no buffer change.
  - `load_valid` while `swap_pending`: expect `load_ready`=0 and no write.
- **Mid-frame reset:** reset during column 3 DRIVE with `swap_pending`=1.
  - Next cycle expect all outputs at reset values and `swap_pending`=0.
  - Scan restarts at column 0 after `BLANK_CYCLES`.
